ppm_tx_sequencer: RTL and testbench
===================================

// Module: ppm_tx_sequencer
// PURPOSE
//  Buffered transmit controller between user/host logic and the PPM Encoder.
//  Queues N_PKT-bit words in a FIFO and drains them into the Encoder via its
//  start/avail handshake. Adds manual (button) or automatic trigger, per-word
//  repeat, an inter-packet gap, and overflow reporting.
//  Sits between board I/O (switches/keys) and Encoder.
// PARAMETERS
//  N_PKT    8     word width, matches Encoder N_PKT
//  DEPTH    16    FIFO depth in words; power of 2, >=2
//  GAP_CT   1000  idle clk cycles between the end of one packet and the next start
//  REPEAT_W 4     width of repeat_ct
// PORTS
//  clk        in  1                 system clock (CLOCK_50 domain)
//  rst_n      in  1                 asynchronous, active-low reset
//  wr_en      in  1                 push wr_data this cycle
//  wr_data    in  N_PKT             word to queue
//  full       out 1                 FIFO holds DEPTH words
//  count      out $clog2(DEPTH)+1   words currently queued
//  overflow   out 1                 sticky: push attempted while full
//  send_n     in  1                 async button, active-low; falling edge triggers a burst
//  auto_mode  in  1                 1 = send whenever FIFO non-empty, no trigger needed
//  repeat_ct  in  REPEAT_W          each word is sent repeat_ct+1 times
//  enc_avail  in  1                 Encoder idle/ready
//  enc_start  out 1                 1-cycle start pulse to Encoder
//  enc_data   out N_PKT             word presented to Encoder
//  busy       out 1                 FSM not in IDLE
//  word_done  out 1                 1-cycle pulse when last repeat of a word completes
// BEHAVIOUR
//  Reset (async, immediate): FIFO empty, count=0, full=0, overflow=0,
//   enc_start=0, enc_data=0, busy=0, word_done=0, FSM=IDLE, gap/repeat counters=0.
//  send_n passes through a 2-FF synchroniser (reset value 1). A trigger is a
//   1->0 transition of the synchronised level.
//  FIFO: push accepted when wr_en && !full, using full from before any same-cycle pop.
//   wr_en && full sets overflow; the word is dropped. Simultaneous push+pop
//   leaves count unchanged. A pop never occurs when the FIFO is empty.
//  FSM states:
//   IDLE   : enter LOAD if !empty && (auto_mode || trigger).
//            A trigger while empty is discarded.
//   LOAD   : pop the head word into enc_data (held stable until the next LOAD).
//            Latch rep = repeat_ct. Go to ARM.
//   ARM    : wait for enc_avail=1, then go to LAUNCH.
//   LAUNCH : enc_start=1 for exactly this cycle. Go to BUSYWT.
//   BUSYWT : wait for enc_avail=0, then go to DONEWT.
//   DONEWT : wait for enc_avail=1 (packet finished). Load gap counter = GAP_CT-1.
//            Go to GAP. If rep==0, pulse word_done this cycle.
//   GAP    : count down to 0. Then:
//            - rep!=0: rep--, go to ARM.
//            - else if !empty: go to LOAD (burst continues).
//            - else: go to IDLE.
//  Manual mode: one trigger drains the whole FIFO, including words pushed
//   during the burst. Triggers while busy are ignored, not queued.
//  Changing auto_mode or repeat_ct mid-word takes effect at the next LOAD / IDLE.
//  Latency: with enc_avail=1 and the FIFO non-empty, enc_start rises 3 clk after
//   the synchronised trigger (IDLE->LOAD->ARM->LAUNCH). Best-case start-to-start
//   = packet time + GAP_CT + 2.
//  Reset mid-packet: enc_start drops at once. The queued data is lost.
//  count is never negative and never exceeds DEPTH. Pointers wrap modulo DEPTH.
// STRUCTURE
//  ppm_pkg: tx_state_t enum {IDLE,LOAD,ARM,LAUNCH,BUSYWT,DONEWT,GAP}, and the
//   default N_PKT/PRE_CT constants shared with Encoder.
//  Sub-module sync_fifo #(WIDTH,DEPTH): single-clock, async reset, with
//   full/empty/count and a registered head output.
//  Synchroniser, edge detect, FSM and counters stay in ppm_tx_sequencer.
// TESTING (Encoder modelled: avail drops 1 clk after start, rises 50 clk later; GAP_CT=4)
//  1. Push 0xA5, 0x3C; auto_mode=0; no trigger -> no enc_start for 200 clk.
//     Then pull send_n low -> enc_data=0xA5 then 0x3C, two starts, then IDLE, count=0.
//  2. auto_mode=1, repeat_ct=2, push 0x81 -> exactly 3 starts with enc_data=0x81,
//     1 word_done after the 3rd, starts spaced 50+1+GAP_CT+2 clk.
//  3. Push DEPTH+1 words with no drain -> full=1, count=DEPTH, overflow=1;
//     the first DEPTH words come out in order.
//  4. Push on the same cycle as a LOAD pop with the FIFO full -> push dropped,
//     overflow=1, count=DEPTH-1.
//  5. Assert rst_n low while in BUSYWT -> enc_start=0, busy=0, count=0 in the same
//     cycle. A trigger after release with the FIFO empty -> no start.
//  6. Trigger while busy, and with enc_avail held 0 in ARM -> no extra burst;
//     enc_start stays low until avail=1.

Source files
------------

// File: rtl/ppm_pkg.sv
// Shared types and default constants for the PPM transmit path.
// The defaults line up with the Encoder's build parameters.
package ppm_pkg;

    localparam int DEF_N_PKT  = 8;
    localparam int DEF_PRE_CT = 100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ARM    = 3'd2,
        LAUNCH = 3'd3,
        BUSYWT = 3'd4,
        DONEWT = 3'd5,
        GAP    = 3'd6
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with occupancy count and a head-of-queue output.
// Pushes are refused when full and pops are refused when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CT  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]   CT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && (count_r != FULL_CT);
    assign pop_ok_s  = pop && (count_r != CT_ZERO);

    // Storage array and write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
        end
    end

    // Read pointer and occupancy; push+pop together leaves count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CT_ZERO;
        end else begin
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CT_ONE;
                2'b01:   count_r <= count_r - CT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == FULL_CT);
    assign empty = (count_r == CT_ZERO);
    assign count = count_r;

endmodule

// File: rtl/ppm_tx_sequencer.sv
// Buffered transmit controller: queues words and feeds them to the PPM Encoder
// with manual/auto triggering, per-word repeat and an inter-packet gap.
module ppm_tx_sequencer
    import ppm_pkg::*;
#(
    parameter int N_PKT    = DEF_N_PKT,
    parameter int DEPTH    = 16,
    parameter int GAP_CT   = 1000,
    parameter int REPEAT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [N_PKT-1:0]       wr_data,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   send_n,
    input  logic                   auto_mode,
    input  logic [REPEAT_W-1:0]    repeat_ct,
    input  logic                   enc_avail,
    output logic                   enc_start,
    output logic [N_PKT-1:0]       enc_data,
    output logic                   busy,
    output logic                   word_done
);

    localparam int GW = $clog2(GAP_CT) + 1;
    localparam logic [GW-1:0]       GAP_LOAD = GW'(GAP_CT - 1);
    localparam logic [GW-1:0]       GAP_ZERO = {GW{1'b0}};
    localparam logic [GW-1:0]       GAP_ONE  = GW'(1);
    localparam logic [REPEAT_W-1:0] REP_ZERO = {REPEAT_W{1'b0}};
    localparam logic [REPEAT_W-1:0] REP_ONE  = REPEAT_W'(1);

    tx_state_t          state_r, state_nx_s;
    logic [1:0]         send_sync_r;
    logic               send_prev_r;
    logic               trigger_s;
    logic               pop_s;
    logic               word_done_s;
    logic [N_PKT-1:0]   fifo_head_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic [GW-1:0]      gap_r;
    logic [REPEAT_W-1:0] rep_r;
    logic               enc_start_r;
    logic               busy_r;
    logic               overflow_r;
    logic [N_PKT-1:0]   enc_data_r;

    sync_fifo #(
        .WIDTH (N_PKT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop_s),
        .head    (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (count)
    );

    // Two-flop synchroniser for the button plus a delayed copy for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_sync_r <= 2'b11;
            send_prev_r <= 1'b1;
        end else begin
            send_sync_r <= {send_sync_r[0], send_n};
            send_prev_r <= send_sync_r[1];
        end
    end

    assign trigger_s = send_prev_r & ~send_sync_r[1];

    // Next-state decode; triggers outside IDLE are simply not looked at
    always_comb begin
        state_nx_s  = state_r;
        pop_s       = 1'b0;
        word_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s && (auto_mode || trigger_s)) state_nx_s = LOAD;
                else                                           state_nx_s = IDLE;
            end
            LOAD: begin
                pop_s      = !fifo_empty_s;
                state_nx_s = ARM;
            end
            ARM: begin
                if (enc_avail) state_nx_s = LAUNCH;
                else           state_nx_s = ARM;
            end
            LAUNCH: state_nx_s = BUSYWT;
            BUSYWT: begin
                if (!enc_avail) state_nx_s = DONEWT;
                else            state_nx_s = BUSYWT;
            end
            DONEWT: begin
                if (enc_avail) begin
                    state_nx_s  = GAP;
                    word_done_s = (rep_r == REP_ZERO);
                end else begin
                    state_nx_s = DONEWT;
                end
            end
            GAP: begin
                if (gap_r != GAP_ZERO)       state_nx_s = GAP;
                else if (rep_r != REP_ZERO)  state_nx_s = ARM;
                else if (!fifo_empty_s)      state_nx_s = LOAD;
                else                         state_nx_s = IDLE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State, counters and registered Encoder-facing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gap_r       <= GAP_ZERO;
            rep_r       <= REP_ZERO;
            enc_start_r <= 1'b0;
            busy_r      <= 1'b0;
            enc_data_r  <= {N_PKT{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            enc_start_r <= (state_nx_s == LAUNCH);
            busy_r      <= (state_nx_s != IDLE);
            if (pop_s) begin
                enc_data_r <= fifo_head_s;
                rep_r      <= repeat_ct;
            end else if (state_r == GAP && gap_r == GAP_ZERO && rep_r != REP_ZERO) begin
                rep_r <= rep_r - REP_ONE;
            end
            if (state_r == DONEWT && enc_avail) begin
                gap_r <= GAP_LOAD;
            end else if (state_r == GAP && gap_r != GAP_ZERO) begin
                gap_r <= gap_r - GAP_ONE;
            end
        end
    end

    // Sticky overflow: any push attempt against a full FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (wr_en && fifo_full_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign full      = fifo_full_s;
    assign overflow  = overflow_r;
    assign enc_start = enc_start_r;
    assign enc_data  = enc_data_r;
    assign busy      = busy_r;
    assign word_done = word_done_s;

endmodule

// File: tb/tb_ppm_tx_sequencer.sv
// Directed bench for ppm_tx_sequencer with a small Encoder model
// (avail drops the cycle after start and returns 50 cycles later).
module tb_ppm_tx_sequencer;

    localparam int N_PKT = 8;
    localparam int DEPTH = 16;
    localparam int GAP_CT = 4;
    localparam int REPEAT_W = 4;
    localparam int PKT_T = 50;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   wr_en = 1'b0;
    logic [N_PKT-1:0]       wr_data = 8'h00;
    logic                   full;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   send_n = 1'b1;
    logic                   auto_mode = 1'b0;
    logic [REPEAT_W-1:0]    repeat_ct = 4'd0;
    logic                   enc_avail;
    logic                   enc_start;
    logic [N_PKT-1:0]       enc_data;
    logic                   busy;
    logic                   word_done;

    logic                   model_avail = 1'b1;
    int                     model_cnt = 0;
    logic                   avail_hold = 1'b0;
    int                     cyc = 0;
    logic [N_PKT-1:0]       start_data[$];
    int                     start_cyc[$];
    int                     wd_n = 0;
    int                     wd_cyc = 0;
    int                     n_tests = 0;
    int                     n_fail = 0;

    ppm_tx_sequencer #(
        .N_PKT    (N_PKT),
        .DEPTH    (DEPTH),
        .GAP_CT   (GAP_CT),
        .REPEAT_W (REPEAT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .send_n    (send_n),
        .auto_mode (auto_mode),
        .repeat_ct (repeat_ct),
        .enc_avail (enc_avail),
        .enc_start (enc_start),
        .enc_data  (enc_data),
        .busy      (busy),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    assign enc_avail = model_avail & ~avail_hold;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (enc_start) begin
            model_avail <= 1'b0;
            model_cnt   <= PKT_T;
        end else if (model_cnt != 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) model_avail <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (enc_start) begin
            start_data.push_back(enc_data);
            start_cyc.push_back(cyc);
        end
        if (word_done) begin
            wd_n   = wd_n + 1;
            wd_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic push_word(input logic [N_PKT-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic clear_log();
        start_data.delete();
        start_cyc.delete();
        wd_n = 0;
    endtask

    initial begin
        int k;
        // reset state
        wait_clk(2);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_enc_start", 32'(enc_start), 32'd0);
        check_eq("rst_enc_data", 32'(enc_data), 32'd0);
        rst_n = 1'b1;
        wait_clk(2);

        // 1: manual trigger drains two words in order
        push_word(8'hA5);
        push_word(8'h3C);
        check_eq("t1_count2", 32'(count), 32'd2);
        wait_clk(200);
        check_eq("t1_no_start", 32'(start_data.size()), 32'd0);
        send_n = 1'b0;
        wait_clk(300);
        send_n = 1'b1;
        check_eq("t1_nstarts", 32'(start_data.size()), 32'd2);
        check_eq("t1_data0", 32'(start_data[0]), 32'hA5);
        check_eq("t1_data1", 32'(start_data[1]), 32'h3C);
        check_eq("t1_idle", 32'(busy), 32'd0);
        check_eq("t1_count0", 32'(count), 32'd0);
        check_eq("t1_word_done", 32'(wd_n), 32'd2);
        clear_log();

        // 2: auto mode with repeat 2 -> three starts, spaced 50+1+4+2
        auto_mode = 1'b1;
        repeat_ct = 4'd2;
        push_word(8'h81);
        wait_clk(250);
        check_eq("t2_nstarts", 32'(start_data.size()), 32'd3);
        for (int i = 0; i < 3; i++) check_eq($sformatf("t2_data%0d", i), 32'(start_data[i]), 32'h81);
        check_eq("t2_space01", 32'(start_cyc[1] - start_cyc[0]), 32'(PKT_T + 1 + GAP_CT + 2));
        check_eq("t2_space12", 32'(start_cyc[2] - start_cyc[1]), 32'(PKT_T + 1 + GAP_CT + 2));
        check_eq("t2_word_done", 32'(wd_n), 32'd1);
        check_eq("t2_wd_after3", 32'(wd_cyc > start_cyc[2]), 32'd1);
        check_eq("t2_idle", 32'(busy), 32'd0);
        auto_mode = 1'b0;
        repeat_ct = 4'd0;
        clear_log();

        // 3: overfill, then drain and check order
        wr_en = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            wr_data = 8'(8'h10 + i);
            if (i == DEPTH - 1) check_eq("t3_no_ovf_yet", 32'(overflow), 32'd0);
            @(negedge clk);
        end
        wr_en = 1'b0;
        check_eq("t3_full", 32'(full), 32'd1);
        check_eq("t3_count", 32'(count), 32'(DEPTH));
        check_eq("t3_overflow", 32'(overflow), 32'd1);
        send_n = 1'b0;
        wait_clk(1100);
        send_n = 1'b1;
        check_eq("t3_nstarts", 32'(start_data.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) check_eq($sformatf("t3_order%0d", i), 32'(start_data[i]), 32'h10 + 32'(i));
        check_eq("t3_ovf_sticky", 32'(overflow), 32'd1);
        clear_log();

        // 4: push on the LOAD pop cycle with the FIFO full
        rst_n = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(2);
        check_eq("t4_ovf_cleared", 32'(overflow), 32'd0);
        wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_data = 8'(8'h20 + i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        check_eq("t4_full", 32'(full), 32'd1);
        send_n = 1'b0;
        k = 0;
        while (busy !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check_eq("t4_busy_seen", 32'(busy), 32'd1);
        push_word(8'hEE);
        check_eq("t4_overflow", 32'(overflow), 32'd1);
        check_eq("t4_count", 32'(count), 32'(DEPTH - 1));

        // 5: reset while in BUSYWT
        k = 0;
        while (enc_start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        check_eq("t5_start_seen", 32'(enc_start), 32'd1);
        @(negedge clk);
        check_eq("t5_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_enc_start", 32'(enc_start), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_count", 32'(count), 32'd0);
        wait_clk(2);
        send_n = 1'b1;
        rst_n = 1'b1;
        wait_clk(3);
        clear_log();
        send_n = 1'b0;
        wait_clk(100);
        send_n = 1'b1;
        check_eq("t5_empty_trig", 32'(start_data.size()), 32'd0);
        check_eq("t5_idle", 32'(busy), 32'd0);

        // 6: avail held low in ARM, extra trigger while busy
        avail_hold = 1'b1;
        push_word(8'h55);
        send_n = 1'b0;
        wait_clk(10);
        check_eq("t6_busy_arm", 32'(busy), 32'd1);
        send_n = 1'b1;
        wait_clk(5);
        send_n = 1'b0;
        wait_clk(40);
        send_n = 1'b1;
        check_eq("t6_no_start", 32'(start_data.size()), 32'd0);
        avail_hold = 1'b0;
        wait_clk(100);
        check_eq("t6_one_start", 32'(start_data.size()), 32'd1);
        check_eq("t6_data", 32'(start_data[0]), 32'h55);
        check_eq("t6_idle", 32'(busy), 32'd0);
        push_word(8'h66);
        wait_clk(100);
        check_eq("t6_no_extra", 32'(start_data.size()), 32'd1);
        check_eq("t6_queued", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
